// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - 7-segment glyphs, BCD decode and conversion FSM states
package seg_pkg;

    // Segment order {a,b,c,d,e,f,g}, active-low
    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_4     = 7'b1001100;
    localparam logic [6:0] GLYPH_5     = 7'b0100100;
    localparam logic [6:0] GLYPH_6     = 7'b0100000;
    localparam logic [6:0] GLYPH_7     = 7'b0001111;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0001100;
    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } conv_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] g;
        case (bcd)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Largest displayable value is pow10(n) - 1
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic                  ovf
);

    localparam int          BCD_W   = 4 * N_DIGITS;
    localparam int          SH_W    = BCD_W + BIN_W;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;

    conv_state_t      state, state_d;
    logic [SH_W-1:0]  shreg;
    logic [SH_W-1:0]  shreg_step;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             ovf_q;

    // Next-state decode; starts are only honoured from idle
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (cnt == CNT_W'(BIN_W - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One double-dabble iteration: add 3 to every digit >= 5, then shift left
    always_comb begin
        logic [SH_W-1:0] adj;
        adj = shreg;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (adj[BIN_W + 4*d +: 4] >= 4'd5) begin
                adj[BIN_W + 4*d +: 4] = adj[BIN_W + 4*d +: 4] + 4'd3;
            end
        end
        shreg_step = {adj[SH_W-2:0], 1'b0};
    end

    // State, shift register, iteration counter, overflow flag and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_d;
            busy_q <= (state == S_SHIFT);
            if (state == S_IDLE && start) begin
                shreg <= {{BCD_W{1'b0}}, value};
                cnt   <= '0;
                ovf_q <= (64'(value) > MAX_VAL);
            end else if (state == S_SHIFT) begin
                shreg <= shreg_step;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    assign busy = busy_q;
    assign done = (state == S_DONE);
    assign bcd  = shreg[BIN_W +: BCD_W];
    assign ovf  = ovf_q;

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed N-digit 7-seg driver; SEG_DIM_EN adds PWM dimming
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int BIN_W         = 14,
    parameter int REFRESH_DIV_W = 16
`ifdef SEG_DIM_EN
    ,
    parameter int DIM_W         = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    value,
    input  logic                load,
    output logic                busy,
    input  logic [N_DIGITS-1:0] dp_mask,
    input  logic                blank_lz,
`ifdef SEG_DIM_EN
    input  logic [DIM_W-1:0]    brightness,
`endif
    output logic [N_DIGITS-1:0] seg_sel,
    output logic [7:0]          segments
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [4*N_DIGITS-1:0]    conv_bcd;
    logic                     conv_ovf;
    logic                     conv_done;

    logic [3:0]               digit_buf [N_DIGITS];
    logic                     ovf_buf;
    logic [REFRESH_DIV_W-1:0] presc;
    logic [IDX_W-1:0]         idx;
    logic [N_DIGITS-1:0]      blank_mask;
    logic [N_DIGITS-1:0]      sel_d;
    logic [7:0]               seg_d;
    logic [6:0]               glyph;
    logic                     above_zero;
    logic                     lit;

    bin2bcd_seq #(
        .BIN_W    (BIN_W),
        .N_DIGITS (N_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (load),
        .value (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // Display buffer: all digits and ovf replaced together when a conversion completes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) digit_buf[i] <= 4'd0;
            ovf_buf <= 1'b0;
        end else if (conv_done) begin
            for (int i = 0; i < N_DIGITS; i++) digit_buf[i] <= conv_bcd[4*i +: 4];
            ovf_buf <= conv_ovf;
        end
    end

    // Refresh prescaler and scan index; index steps on prescaler terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc + REFRESH_DIV_W'(1);
            if (presc == {REFRESH_DIV_W{1'b1}}) begin
                if (idx == IDX_W'(N_DIGITS - 1)) idx <= '0;
                else                             idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef SEG_DIM_EN
    logic [DIM_W-1:0] pwm_cnt;

    // Free-running PWM counter; select lines are gated off once it reaches brightness
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + DIM_W'(1);
    end

    assign lit = (pwm_cnt < brightness);
`else
    assign lit = 1'b1;
`endif

    // Leading-zero mask from the buffer, then glyph and dp for the current digit
    always_comb begin
        above_zero = 1'b1;
        blank_mask = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            above_zero    = above_zero && (digit_buf[i] == 4'd0);
            blank_mask[i] = blank_lz && above_zero;
        end
        if (ovf_buf)                glyph = GLYPH_DASH;
        else if (blank_mask[idx])   glyph = GLYPH_BLANK;
        else                        glyph = bcd_to_seg(digit_buf[idx]);
        seg_d = {glyph, ~dp_mask[idx]};
        for (int i = 0; i < N_DIGITS; i++) begin
            sel_d[i] = !(lit && (idx == IDX_W'(i)));
        end
    end

    // Select and segment registers update on the same edge so no ghost cycle appears
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_sel  <= '1;
            segments <= 8'hFF;
        end else begin
            seg_sel  <= sel_d;
            segments <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

`ifdef SEG_DIM_EN
    localparam bit DIM_BUILD = 1'b1;
`else
    localparam bit DIM_BUILD = 1'b0;
`endif

    localparam logic [7:0] S0    = 8'h03;
    localparam logic [7:0] S1    = 8'h9F;
    localparam logic [7:0] S2    = 8'h25;
    localparam logic [7:0] S3    = 8'h0D;
    localparam logic [7:0] S4    = 8'h99;
    localparam logic [7:0] S5    = 8'h49;
    localparam logic [7:0] S7    = 8'h1F;
    localparam logic [7:0] S8    = 8'h01;
    localparam logic [7:0] SDASH = 8'hFD;
    localparam logic [7:0] SBLNK = 8'hFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value = '0;
    logic        load = 1'b0;
    logic        busy;
    logic [3:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  seg_sel;
    logic [7:0]  segments;
`ifdef SEG_DIM_EN
    logic [3:0]  brightness = 4'd15;
`endif

    int errors = 0;
    int checks = 0;

    logic [3:0] cap_sel [17];
    logic [7:0] cap_seg [17];
    logic [7:0] exp_seg [4];

    always #5 clk = ~clk;

    seg_scan_driver #(
        .N_DIGITS      (4),
        .BIN_W         (14),
        .REFRESH_DIV_W (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .busy       (busy),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
`ifdef SEG_DIM_EN
        .brightness (brightness),
`endif
        .seg_sel    (seg_sel),
        .segments   (segments)
    );

    // Called at a negedge; load is sampled by the following posedge
    task automatic do_load(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Called right after do_load; returns at the first negedge with busy low again
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 60 && !ok; t++) begin
            if (busy === 1'b0) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    // Aligns on the 0111 -> 1110 wrap and records 17 consecutive samples
    task automatic capture(output bit ok);
        logic [3:0] last;
        last = 4'hF;
        ok   = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (seg_sel !== 4'hF) begin
                if (seg_sel === 4'b1110 && last === 4'b0111) ok = 1'b1;
                last = seg_sel;
            end
        end
        cap_sel[0] = seg_sel;
        cap_seg[0] = segments;
        for (int n = 1; n < 17; n++) begin
            @(negedge clk);
            cap_sel[n] = seg_sel;
            cap_seg[n] = segments;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (seg_sel !== 4'hF) begin
            errors++; $display("FAIL reset_sel: got %b want 1111", seg_sel);
        end
        checks++;
        if (segments !== 8'hFF) begin
            errors++; $display("FAIL reset_seg: got %h want ff", segments);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_convert();
        int  nbusy;
        bit  seen;
        bit  ok;
        do_load(14'd1234);
        nbusy = 0;
        seen  = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                nbusy++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        checks++;
        if (nbusy != 14) begin
            errors++; $display("FAIL busy_len: got %0d want 14", nbusy);
        end
        exp_seg = '{S4, S3, S2, S1};
        capture(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL conv_scan_sync: got 0 want 1");
        end
        for (int n = 0; n < 17; n++) begin
            logic [3:0] es;
            es = ~(4'b0001 << ((n / 4) % 4));
            checks++;
            if (cap_sel[n] !== es && !(DIM_BUILD && cap_sel[n] === 4'hF)) begin
                errors++; $display("FAIL conv_sel[%0d]: got %b want %b", n, cap_sel[n], es);
            end
            checks++;
            if (cap_seg[n] !== exp_seg[(n / 4) % 4]) begin
                errors++; $display("FAIL conv_seg[%0d]: got %h want %h", n, cap_seg[n], exp_seg[(n / 4) % 4]);
            end
        end
    endtask

    task automatic test_blanking();
        bit ok;
        blank_lz = 1'b1;
        for (int v = 0; v < 2; v++) begin
            do_load(v == 0 ? 14'd7 : 14'd0);
            wait_idle(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL blank_idle: got 0 want 1");
            end
            exp_seg = '{(v == 0 ? S7 : S0), SBLNK, SBLNK, SBLNK};
            capture(ok);
            for (int n = 0; n < 16; n++) begin
                checks++;
                if (cap_seg[n] !== exp_seg[n / 4]) begin
                    errors++; $display("FAIL blank_seg v%0d[%0d]: got %h want %h", v, n, cap_seg[n], exp_seg[n / 4]);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_overflow();
        bit ok;
        dp_mask = 4'b0100;
        do_load(14'd12000);
        wait_idle(ok);
        exp_seg = '{SDASH, SDASH, SDASH & 8'hFE, SDASH};
        capture(ok);
        for (int n = 0; n < 16; n++) begin
            checks++;
            if (cap_seg[n] !== exp_seg[n / 4]) begin
                errors++; $display("FAIL ovf_seg[%0d]: got %h want %h", n, cap_seg[n], exp_seg[n / 4]);
            end
        end
        dp_mask = 4'b0000;
        do_load(14'd42);
        wait_idle(ok);
        exp_seg = '{S2, S4, S0, S0};
        capture(ok);
        for (int n = 0; n < 16; n++) begin
            checks++;
            if (cap_seg[n] !== exp_seg[n / 4]) begin
                errors++; $display("FAIL ovf_clear_seg[%0d]: got %h want %h", n, cap_seg[n], exp_seg[n / 4]);
            end
        end
    endtask

    task automatic test_dp_scan();
        bit ok;
        dp_mask = 4'b0100;
        capture(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL dp_scan_sync: got 0 want 1");
        end
        for (int n = 0; n < 17; n++) begin
            logic [3:0] es;
            logic       edp;
            es  = ~(4'b0001 << ((n / 4) % 4));
            edp = (es === 4'b1011) ? 1'b0 : 1'b1;
            checks++;
            if (cap_sel[n] !== es && !(DIM_BUILD && cap_sel[n] === 4'hF)) begin
                errors++; $display("FAIL dp_sel[%0d]: got %b want %b", n, cap_sel[n], es);
            end
            checks++;
            if (cap_seg[n][0] !== edp) begin
                errors++; $display("FAIL dp_bit[%0d]: got %b want %b", n, cap_seg[n][0], edp);
            end
        end
        dp_mask = 4'b0000;
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_load(14'd5);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_busy_mid: got %b want 1", busy);
        end
        do_load(14'd9);
        wait_idle(ok);
        exp_seg = '{S5, S0, S0, S0};
        capture(ok);
        for (int n = 0; n < 16; n++) begin
            checks++;
            if (cap_seg[n] !== exp_seg[n / 4]) begin
                errors++; $display("FAIL drop_seg[%0d]: got %h want %h", n, cap_seg[n], exp_seg[n / 4]);
            end
        end
        do_load(14'd3);
        wait_idle(ok);
        do_load(14'd8);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got %b want 1", busy);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL b2b_idle: got 0 want 1");
        end
        exp_seg = '{S8, S0, S0, S0};
        capture(ok);
        for (int n = 0; n < 16; n++) begin
            checks++;
            if (cap_seg[n] !== exp_seg[n / 4]) begin
                errors++; $display("FAIL b2b_seg[%0d]: got %h want %h", n, cap_seg[n], exp_seg[n / 4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_load(14'd1234);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_busy: got %b want 0", busy);
        end
        checks++;
        if (seg_sel !== 4'hF || segments !== 8'hFF) begin
            errors++; $display("FAIL rstmid_out: got %b/%h want 1111/ff", seg_sel, segments);
        end
        rst = 1'b0;
        exp_seg = '{S0, S0, S0, S0};
        capture(ok);
        for (int n = 0; n < 16; n++) begin
            checks++;
            if (cap_seg[n] !== exp_seg[n / 4]) begin
                errors++; $display("FAIL rstmid_seg[%0d]: got %h want %h", n, cap_seg[n], exp_seg[n / 4]);
            end
        end
    endtask

`ifdef SEG_DIM_EN
    task automatic test_dim();
        int on_cnt;
        brightness = 4'd4;
        repeat (3) @(negedge clk);
        on_cnt = 0;
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            if (seg_sel !== 4'hF) on_cnt++;
        end
        checks++;
        if (on_cnt != 8) begin
            errors++; $display("FAIL dim4_on: got %0d want 8", on_cnt);
        end
        brightness = 4'd0;
        repeat (3) @(negedge clk);
        on_cnt = 0;
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            if (seg_sel !== 4'hF) on_cnt++;
        end
        checks++;
        if (on_cnt != 0) begin
            errors++; $display("FAIL dim0_on: got %0d want 0", on_cnt);
        end
        brightness = 4'd15;
    endtask
`endif

    initial begin
        test_reset();
        test_convert();
        test_blanking();
        test_overflow();
        test_dp_scan();
        test_back_to_back();
        test_reset_mid();
`ifdef SEG_DIM_EN
        test_dim();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
